// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with sequential byte addressing and a 2-entry
// output FIFO between valid/ready handshakes.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_fmt,
  output logic [1:0]            count
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 2;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [INSTR_W-1:0]    enc_c;
  logic                  legal_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;

  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  valid_q,      valid_d;
  logic [INSTR_W-1:0]    head_instr_q, head_instr_d;
  logic [ADDR_WIDTH-1:0] head_addr_q,  head_addr_d;
  logic [INSTR_W-1:0]    tail_instr_q, tail_instr_d;
  logic [ADDR_WIDTH-1:0] tail_addr_q,  tail_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic                  err_q,        err_d;

  // Field packing per instruction format.
  always_comb begin
    enc_c = '0;
    unique case (fmt)
      FMT_R:   enc_c = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   enc_c = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   enc_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   enc_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   enc_c = {imm[31:12], rd, opcode};
      FMT_J:   enc_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_c = '0;
    endcase
  end

  assign legal_c  = (fmt <= FMT_J);
  assign in_ready = (cnt_q != CNT_W'(2)) || out_ready;
  assign accept_c = in_valid && in_ready;
  assign push_c   = accept_c && legal_c;
  assign pop_c    = valid_q && out_ready;

  // Buffer, address counter and error pulse next-state.
  always_comb begin
    cnt_d        = cnt_q;
    head_instr_d = head_instr_q;
    head_addr_d  = head_addr_q;
    tail_instr_d = tail_instr_q;
    tail_addr_d  = tail_addr_q;
    addr_d       = addr_q;
    err_d        = accept_c && !legal_c;

    if (push_c) begin
      addr_d = addr_q + STEP;
    end

    unique case (cnt_q)
      CNT_W'(0): begin
        if (push_c) begin
          head_instr_d = enc_c;
          head_addr_d  = addr_q;
          cnt_d        = CNT_W'(1);
        end
      end
      CNT_W'(1): begin
        if (push_c && pop_c) begin
          head_instr_d = enc_c;
          head_addr_d  = addr_q;
        end else if (push_c) begin
          tail_instr_d = enc_c;
          tail_addr_d  = addr_q;
          cnt_d        = CNT_W'(2);
        end else if (pop_c) begin
          cnt_d = CNT_W'(0);
        end
      end
      CNT_W'(2): begin
        if (pop_c) begin
          head_instr_d = tail_instr_q;
          head_addr_d  = tail_addr_q;
          if (push_c) begin
            tail_instr_d = enc_c;
            tail_addr_d  = addr_q;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end
      default: cnt_d = CNT_W'(0);
    endcase

    valid_d = (cnt_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      head_instr_q <= '0;
      head_addr_q  <= '0;
      tail_instr_q <= '0;
      tail_addr_q  <= '0;
      addr_q       <= BASE;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      head_instr_q <= head_instr_d;
      head_addr_q  <= head_addr_d;
      tail_instr_q <= tail_instr_d;
      tail_addr_q  <= tail_addr_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = head_instr_q;
  assign out_addr  = head_addr_q;
  assign err_fmt   = err_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder; two instances (8-bit base 0,
// 4-bit base 0xC) share stimulus and are compared against a queue-based model.
module tb_instr_encoder;

  localparam int unsigned N_RAND = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, err_a;
  logic [31:0] instr_a;
  logic [7:0]  addr_a;
  logic [1:0]  count_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [31:0] instr_b;
  logic [3:0]  addr_b;
  logic [1:0]  count_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(instr_a),
    .out_addr(addr_a), .err_fmt(err_a), .count(count_a)
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(instr_b),
    .out_addr(addr_b), .err_fmt(err_b), .count(count_b)
  );

  // Reference model: FIFO of (word, legal-bundle ordinal since reset).
  typedef struct {
    logic [31:0] instr;
    int unsigned k;
  } ent_t;
  ent_t        q[$];
  int unsigned nlegal;
  logic        err_m;

  function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] r;
    logic [31:0] common;
    common = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: r = (32'(f7) << 25) | (32'(s2) << 20) | common | (32'(d) << 7);
      3'd1: r = ((im & 32'hFFF) << 20) | common | (32'(d) << 7);
      3'd2: r = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | common | ((im & 32'h1F) << 7);
      3'd3: r = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                | common | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      3'd4: r = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
      3'd5: r = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                | (32'(d) << 7) | 32'(op);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count_a", 32'(count_a), 32'(q.size()));
    check("count_b", 32'(count_b), 32'(q.size()));
    check("valid_a", 32'(out_valid_a), 32'(q.size() != 0));
    check("valid_b", 32'(out_valid_b), 32'(q.size() != 0));
    check("err_a", 32'(err_a), 32'(err_m));
    check("err_b", 32'(err_b), 32'(err_m));
    if (q.size() != 0) begin
      check("instr_a", instr_a, q[0].instr);
      check("instr_b", instr_b, q[0].instr);
      check("addr_a", 32'(addr_a), (4 * q[0].k) % 256);
      check("addr_b", 32'(addr_b), (12 + 4 * q[0].k) % 16);
    end
  endtask

  task automatic set_bundle(input logic v, input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    in_valid = v; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  // One clock: check state, check in_ready, advance model on the edge.
  task automatic cycle();
    logic rdy_m, acc, pop;
    logic [31:0] w;
    check_outputs();
    #1;
    rdy_m = (q.size() < 2) || out_ready;
    check("in_ready_a", 32'(in_ready_a), 32'(rdy_m));
    check("in_ready_b", 32'(in_ready_b), 32'(rdy_m));
    @(posedge clk);
    acc = in_valid && rdy_m;
    pop = (q.size() != 0) && out_ready;
    w   = ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    err_m = acc && (fmt > 3'd5);
    if (pop) void'(q.pop_front());
    if (acc && fmt <= 3'd5) begin
      q.push_back('{instr: w, k: nlegal});
      nlegal++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid_a", 32'(out_valid_a), 32'h0);
    check("rst_valid_b", 32'(out_valid_b), 32'h0);
    check("rst_count_a", 32'(count_a), 32'h0);
    check("rst_instr_a", instr_a, 32'h0);
    check("rst_addr_a", 32'(addr_a), 32'h0);
    check("rst_err_a", 32'(err_a), 32'h0);
    q.delete();
    nlegal = 0;
    err_m  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle();
    set_bundle(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle();
    nlegal = 0;
    err_m  = 1'b0;
    @(negedge clk);
    do_reset();

    // add x3,x1,x2
    set_bundle(1'b1, 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    cycle();
    idle();
    check("add_word", instr_a, 32'h002081B3);
    check("add_addr", 32'(addr_a), 32'h0);
    cycle();

    // I/S/U/J stream from a fresh address counter
    do_reset();
    set_bundle(1'b1, 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    cycle();
    check("addi_word", instr_a, 32'h00500093);
    set_bundle(1'b1, 3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    cycle();
    check("sw_word", instr_a, 32'h0020A423);
    check("sw_addr", 32'(addr_a), 32'h4);
    set_bundle(1'b1, 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    cycle();
    check("lui_word", instr_a, 32'h123452B7);
    check("lui_addr", 32'(addr_a), 32'h8);
    set_bundle(1'b1, 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    cycle();
    check("jal_word", instr_a, 32'h008000EF);
    check("jal_addr", 32'(addr_a), 32'hC);
    set_bundle(1'b1, 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    cycle();
    check("beq_word", instr_a, 32'hFE208EE3);
    idle();
    cycle();

    // Illegal fmt sandwiched between legal bundles; wrap on the 4-bit instance
    do_reset();
    set_bundle(1'b1, 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    cycle();
    set_bundle(1'b1, 3'd6, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    cycle();
    set_bundle(1'b1, 3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    cycle();
    check("ill_err_pulse", 32'(err_a), 32'h0);
    check("ill_addr2_a", 32'(addr_a), 32'h4);
    check("wrap_addr_b", 32'(addr_b), 32'h0);
    idle();
    cycle();

    // Backpressure: fill, stall, then same-edge push+pop at count 2
    out_ready = 1'b0;
    set_bundle(1'b1, 3'd0, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    cycle();
    set_bundle(1'b1, 3'd0, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 32'd0);
    cycle();
    set_bundle(1'b1, 3'd0, 7'b0110011, 5'd10, 5'd11, 5'd12, 3'd0, 7'd0, 32'd0);
    cycle();
    cycle();
    check("bp_stall_ready", 32'(in_ready_a), 32'h0);
    out_ready = 1'b1;
    cycle();
    check("bp_pushpop_count", 32'(count_a), 32'h2);
    idle();
    out_ready = 1'b0;
    cycle();

    // Reset with a full buffer, then first bundle restarts at base
    check("pre_reset_full", 32'(count_a), 32'h2);
    do_reset();
    out_ready = 1'b1;
    set_bundle(1'b1, 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    cycle();
    check("post_reset_addr_b", 32'(addr_b), 32'hC);
    idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < int'(N_RAND); i++) begin
      set_bundle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 7'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle();
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
